hack_mem_arb: RTL

Single-port data-RAM arbiter placed between the Hack CPU data port (addressM/writeM/outM/inM) and the video scan-out reader. CPU has priority; video gets the port on idle cycles or, optionally, after a bounded wait. The block sequences CPU reads over two cycles via `cpu_stall`, a clock-enable to the CPU core. CPU writes complete in their grant cycle.

---
 rtl/hack_mem_pkg.sv | 21 ++
 rtl/hack_mem_arb_if.sv | 48 ++++
 rtl/hack_arb_starve_ctr.sv | 32 +++
 rtl/hack_mem_arb.sv | 107 ++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared types and default widths for the Hack data-RAM arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default RAM word-address and data widths
//   arb_state_t             : arbiter FSM state
//   gnt_src_t               : which requester owns the RAM port this cycle
package hack_mem_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    IDLE,
    CPU_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_VID
  } gnt_src_t;

endpackage

// File: rtl/hack_mem_arb_if.sv
// hack_mem_arb_if: CPU data port, video reader port and RAM port of the arbiter.
//   slave  : arbiter side (takes requests, drives grants and RAM strobes)
//   master : environment side (CPU, video reader and RAM)
interface hack_mem_arb_if
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  vid_req, vid_addr,
    output vid_gnt, vid_valid, vid_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output vid_req, vid_addr,
    input  vid_gnt, vid_valid, vid_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/hack_arb_starve_ctr.sv
// hack_arb_starve_ctr: counts cycles a video request has waited ungranted.
//   clk, reset : clock, synchronous active-high reset
//   vid_req    : video request pending
//   vid_gnt    : video granted this cycle
//   starve     : count has reached MAX_WAIT; video must be served now
module hack_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic vid_req,
  input  logic vid_gnt,
  output logic starve
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (vid_gnt || !vid_req) begin
      count <= '0;
    end else if (count != CNT_W'(MAX_WAIT)) begin
      count <= count + 1'b1;
    end
  end

  assign starve = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/hack_mem_arb.sv
// hack_mem_arb: single-port data-RAM arbiter between the Hack CPU data port
// and the video scan-out reader. CPU has priority; CPU reads take two cycles
// (stall, then data), writes complete in their grant cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hack_mem_arb_if.slave (CPU, video and RAM ports)
// Build option: define HACK_ARB_STARVE_GUARD_EN to force a video grant after
// MAX_WAIT ungranted cycles even while the CPU is requesting.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no CPU read outstanding
// CPU_RESP | granted CPU read returns; only video may be granted
module hack_mem_arb
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  hack_mem_arb_if.slave   bus
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("hack_mem_arb: MAX_WAIT must be at least 1");
  end

  arb_state_t        state, state_nxt;
  gnt_src_t          gnt_src;
  logic              starve;
  logic              cpu_wr_gnt;
  logic              vid_gnt;
  logic              vid_valid_q;
  logic              ram_en;
  logic              ram_we;
  logic              cpu_stall;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata;

`ifdef HACK_ARB_STARVE_GUARD_EN
  hack_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .vid_req (bus.vid_req),
    .vid_gnt (vid_gnt),
    .starve  (starve)
  );
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vid_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      vid_valid_q <= vid_gnt;
    end
  end

  // In CPU_RESP the CPU request is the one already in flight, so it is
  // never re-granted; the port is free for video.
  always_comb begin
    gnt_src = GNT_NONE;
    if (!reset) begin
      if (state == IDLE) begin
        if (bus.cpu_req && !starve) begin
          gnt_src = GNT_CPU;
        end else if (bus.vid_req) begin
          gnt_src = GNT_VID;
        end
      end else if (bus.vid_req) begin
        gnt_src = GNT_VID;
      end
    end
  end

  always_comb begin
    cpu_wr_gnt = (gnt_src == GNT_CPU) && bus.cpu_we;
    vid_gnt    = (gnt_src == GNT_VID);
    ram_en     = (gnt_src != GNT_NONE);
    ram_we     = cpu_wr_gnt;
    addr_mux   = vid_gnt ? bus.vid_addr : bus.cpu_addr;
    wdata      = bus.cpu_wdata;
    cpu_stall  = !reset && bus.cpu_req && !cpu_wr_gnt && (state != CPU_RESP);
    state_nxt  = IDLE;
    if ((state == IDLE) && (gnt_src == GNT_CPU) && !bus.cpu_we) begin
      state_nxt = CPU_RESP;
    end
  end

  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = addr_mux;
  assign bus.ram_wdata = wdata;
  assign bus.cpu_stall = cpu_stall;
  assign bus.vid_gnt   = vid_gnt;
  assign bus.vid_valid = vid_valid_q;
  // RAM read data is shared; each consumer knows when it is meaningful.
  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.vid_rdata = bus.ram_rdata;

endmodule
